// File: rtl/rr_operand_arbiter.sv
// rr_operand_arbiter
//   Round-robin feeder for the 2:1 operand mux (out = C ? A : B). Two
//   valid/ready operand streams compete for a single-entry output register.
//   A tie goes to the source the priority pointer names, and the pointer
//   flips to the other source after every transfer.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   a_valid/a_data/a_ready   operand stream A (sel = 1)
//   b_valid/b_data/b_ready   operand stream B (sel = 0)
//   sel        combinational grant, drives the downstream mux C input
//   out_valid/out_data/out_src/out_ready   registered output stream
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_EMPTY | output register holds nothing; any grant loads it
// ST_FULL  | output register holds an operand; a grant loads only when
//          | out_ready drains it in the same cycle

module rr_operand_arbiter #(
   parameter int WIDTH    = 4,
   parameter bit PRIO_RST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   output logic             sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t           state_q;
   logic             prio_q;
   logic [WIDTH-1:0] data_q;
   logic             src_q;

   logic             can_load;
   logic             grant;
   logic             xfer;
   logic [WIDTH-1:0] data_d;

   // A full register may reload in the cycle it drains.
   assign can_load = (state_q == ST_EMPTY) || out_ready;

   // With no requester, sel parks on the pointer so the mux select stays quiet.
   always_comb begin
      sel = prio_q;
      if (a_valid && b_valid) sel = prio_q;
      else if (a_valid)       sel = 1'b1;
      else if (b_valid)       sel = 1'b0;
   end

   assign grant   = a_valid || b_valid;
   assign xfer    = grant && can_load && !rst;
   assign a_ready = can_load && a_valid &&  sel && !rst;
   assign b_ready = can_load && b_valid && !sel && !rst;
   assign data_d  = sel ? a_data : b_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         src_q   <= 1'b0;
         prio_q  <= PRIO_RST;
      end else begin
         // The pointer moves only on a transfer, so a stalled loser keeps its turn.
         if (xfer) begin
            data_q <= data_d;
            src_q  <= sel;
            prio_q <= !sel;
         end
         case (state_q)
            ST_EMPTY: begin
               if (xfer) state_q <= ST_FULL;
            end
            ST_FULL: begin
               if (out_ready && !xfer) state_q <= ST_EMPTY;
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

   assign out_valid = (state_q == ST_FULL);
   assign out_data  = data_q;
   assign out_src   = src_q;

endmodule

// File: tb/tb_rr_operand_arbiter.sv
module tb_rr_operand_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_valid, b_valid, out_ready;
   logic [3:0] a_data, b_data;
   logic       a_ready, b_ready, sel, out_valid, out_src;
   logic [3:0] out_data;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rr_operand_arbiter #(.WIDTH(4), .PRIO_RST(1'b1)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .sel(sel),
      .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
      .out_ready(out_ready)
   );

   typedef struct {
      logic       rst, av, bv;
      logic [3:0] ad, bd;
      logic       ordy;
      logic       e_ar, e_br, e_sel;   // before the edge
      logic       e_ov;                // after the edge
      logic [3:0] e_od;
      logic       e_os;
   } vec_t;

   vec_t vecs[21];

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(logic r, logic av, logic bv, logic [3:0] ad, logic [3:0] bd,
                               logic ordy, logic ar, logic br, logic s,
                               logic ov, logic [3:0] od, logic os);
      vec_t v;
      v.rst = r; v.av = av; v.bv = bv; v.ad = ad; v.bd = bd; v.ordy = ordy;
      v.e_ar = ar; v.e_br = br; v.e_sel = s; v.e_ov = ov; v.e_od = od; v.e_os = os;
      return v;
   endfunction

   // Behavioural reference: output slot as a queue of at most one {src,data}
   // entry, and the name of the source that wins the next tie.
   typedef struct { logic src; logic [3:0] data; } ent_t;
   ent_t slot[$];
   logic tie_to_a;
   logic [3:0] last_data;
   logic       last_src;

   initial begin
      // rst av bv ad bd ordy | ar br sel | ov od os
      vecs[0]  = mk(1,1,1,4'h3,4'hC,1, 0,0,1, 0,4'h0,0);
      vecs[1]  = mk(1,1,1,4'h3,4'hC,1, 0,0,1, 0,4'h0,0);
      vecs[2]  = mk(0,1,1,4'h3,4'hC,1, 1,0,1, 1,4'h3,1);
      vecs[3]  = mk(0,1,1,4'h3,4'hC,1, 0,1,0, 1,4'hC,0);
      vecs[4]  = mk(0,1,1,4'h3,4'hC,1, 1,0,1, 1,4'h3,1);
      vecs[5]  = mk(0,1,1,4'h3,4'hC,1, 0,1,0, 1,4'hC,0);
      vecs[6]  = mk(0,0,1,4'h0,4'h5,1, 0,1,0, 1,4'h5,0);
      vecs[7]  = mk(0,0,1,4'h0,4'h5,1, 0,1,0, 1,4'h5,0);
      vecs[8]  = mk(0,0,1,4'h0,4'h5,1, 0,1,0, 1,4'h5,0);
      vecs[9]  = mk(0,1,1,4'h9,4'h5,1, 1,0,1, 1,4'h9,1);
      vecs[10] = mk(0,1,0,4'h6,4'h0,0, 0,0,1, 1,4'h9,1);
      vecs[11] = mk(0,1,0,4'h6,4'h0,0, 0,0,1, 1,4'h9,1);
      vecs[12] = mk(0,1,0,4'h6,4'h0,0, 0,0,1, 1,4'h9,1);
      vecs[13] = mk(0,1,0,4'h6,4'h0,1, 1,0,1, 1,4'h6,1);
      vecs[14] = mk(0,1,0,4'hF,4'h0,1, 1,0,1, 1,4'hF,1);
      vecs[15] = mk(0,0,0,4'h0,4'h0,1, 0,0,0, 0,4'hF,1);
      vecs[16] = mk(0,0,0,4'h0,4'h0,1, 0,0,0, 0,4'hF,1);
      vecs[17] = mk(0,1,1,4'h3,4'hC,1, 0,1,0, 1,4'hC,0);
      vecs[18] = mk(0,0,0,4'h0,4'h0,0, 0,0,1, 1,4'hC,0);
      vecs[19] = mk(1,1,1,4'h3,4'hC,0, 0,0,1, 0,4'h0,0);
      vecs[20] = mk(0,0,1,4'h0,4'h7,0, 0,1,0, 1,4'h7,0);

      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 21; i++) begin
         rst = vecs[i].rst; a_valid = vecs[i].av; b_valid = vecs[i].bv;
         a_data = vecs[i].ad; b_data = vecs[i].bd; out_ready = vecs[i].ordy;
         @(negedge clk);
         chk($sformatf("v%0d a_ready", i), {3'b0, a_ready}, {3'b0, vecs[i].e_ar});
         chk($sformatf("v%0d b_ready", i), {3'b0, b_ready}, {3'b0, vecs[i].e_br});
         chk($sformatf("v%0d sel", i),     {3'b0, sel},     {3'b0, vecs[i].e_sel});
         @(posedge clk); #1;
         chk($sformatf("v%0d out_valid", i), {3'b0, out_valid}, {3'b0, vecs[i].e_ov});
         chk($sformatf("v%0d out_data", i),  out_data,           vecs[i].e_od);
         chk($sformatf("v%0d out_src", i),   {3'b0, out_src},   {3'b0, vecs[i].e_os});
      end

      // Hand-written: full stall across several cycles, then reset mid-stall.
      rst = 1'b0; a_valid = 1'b1; b_valid = 1'b0; a_data = 4'hA; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; a_data = 4'h2; b_valid = 1'b1; b_data = 4'hB;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall no ready", {2'b0, a_ready, b_ready}, 4'h0);
         @(posedge clk); #1;
         chk("stall hold data", out_data, 4'hA);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst mid-stall out_valid", {3'b0, out_valid}, 4'h0);
      chk("rst mid-stall out_data", out_data, 4'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst mid-stall prio", {3'b0, sel}, 4'h1);   // both valid: pointer back to A

      // Randomized phase against the reference model, starting from reset.
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
      @(posedge clk); #1;
      slot.delete(); tie_to_a = 1'b1; last_data = '0; last_src = 1'b0;
      for (int c = 0; c < 400; c++) begin
         logic pick_a, any, room, e_ar, e_br, e_sel;
         rst       = ($urandom_range(0, 39) == 0);
         a_valid   = $urandom_range(0, 1);
         b_valid   = $urandom_range(0, 1);
         a_data    = 4'($urandom);
         b_data    = 4'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);

         any    = a_valid || b_valid;
         pick_a = (a_valid && b_valid) ? tie_to_a : a_valid;
         e_sel  = any ? pick_a : tie_to_a;
         room   = (slot.size() == 0) || out_ready;
         e_ar   = !rst && room && a_valid && pick_a;
         e_br   = !rst && room && b_valid && !pick_a;

         @(negedge clk);
         chk("rnd a_ready", {3'b0, a_ready}, {3'b0, e_ar});
         chk("rnd b_ready", {3'b0, b_ready}, {3'b0, e_br});
         if (!rst) chk("rnd sel", {3'b0, sel}, {3'b0, e_sel});
         chk("rnd out_valid pre", {3'b0, out_valid}, {3'b0, slot.size() != 0});
         if (slot.size() != 0) begin
            chk("rnd out_data", out_data, slot[0].data);
            chk("rnd out_src", {3'b0, out_src}, {3'b0, slot[0].src});
         end else begin
            chk("rnd stale data", out_data, last_data);
         end

         if (rst) begin
            slot.delete(); tie_to_a = 1'b1; last_data = '0; last_src = 1'b0;
         end else begin
            if (out_ready && slot.size() != 0) void'(slot.pop_front());
            if (e_ar || e_br) begin
               ent_t e;
               e.src  = e_ar;
               e.data = e_ar ? a_data : b_data;
               slot.push_back(e);
               last_data = e.data; last_src = e.src;
               tie_to_a  = !e_ar;
            end
         end
         @(posedge clk); #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
